div_unit: RTL



---
 rtl/div_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU, RISC-V semantics) for the execute stage.
// One quotient bit per cycle; fixed WIDTH+1 cycle latency from accepted start to done.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       DivCode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DivResult
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] babs_q;
    logic [WIDTH-1:0] a_q;
    logic [CW-1:0]    cnt_q;
    logic             rem_op_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             bzero_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] res_q;

    logic             is_signed;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   shifted;
    logic             trial_ok;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] res_d;

    always_comb begin
        is_signed = ~DivCode[0];
        a_abs     = (is_signed && A[WIDTH-1]) ? ('0 - A) : A;
        b_abs     = (is_signed && B[WIDTH-1]) ? ('0 - B) : B;
    end

    // The shifted remainder is below 2*|B|, so the difference always fits in WIDTH bits
    // once the WIDTH+1 bit compare says the subtraction succeeds.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial_ok = (shifted >= {1'b0, babs_q});
        trial    = shifted[WIDTH-1:0] - babs_q;
    end

    always_comb begin
        res_d = '0;
        if (bzero_q) begin
            res_d = rem_op_q ? a_q : '1;
        end else if (ovf_q) begin
            res_d = rem_op_q ? '0 : MIN_NEG;
        end else if (rem_op_q) begin
            res_d = neg_rem_q ? ('0 - rem_q) : rem_q;
        end else begin
            res_d = neg_quo_q ? ('0 - quo_q) : quo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            babs_q    <= '0;
            a_q       <= '0;
            cnt_q     <= '0;
            rem_op_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        rem_q     <= '0;
                        quo_q     <= a_abs;
                        babs_q    <= b_abs;
                        a_q       <= A;
                        cnt_q     <= '0;
                        rem_op_q  <= DivCode[1];
                        neg_quo_q <= is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_rem_q <= is_signed && A[WIDTH-1];
                        bzero_q   <= (B == '0);
                        ovf_q     <= is_signed && (A == MIN_NEG) && (B == '1);
                        busy_q    <= 1'b1;
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        rem_q <= trial_ok ? trial : shifted[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], trial_ok};
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (!flush) begin
                        res_q  <= res_d;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign DivResult = res_q;

endmodule
